// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot-product sequencer.
//   state_t    : 2-bit FSM encoding (IDLE=0, LOAD=1, MAC=2, DONE=3)
//   DEF_N/DEF_W: default vector length and element width
//   acc_width  : accumulator width that cannot overflow for n elements of w bits
//   cnt_width  : element counter width (at least one bit)
package dot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_N = 3;
  localparam int DEF_W = 8;

  // n products of at most (2^w-1)^2 each sum to less than 2^(2w+clog2(n)).
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dot_seq_ctrl_if.sv
// Request/grant/result bundle between two requesters and dot_seq_ctrl.
//   req0/req1        : requests (requester -> controller)
//   a0/b0, a1/b1     : operand vectors, element 0 in the MSB slice
//   gnt0/gnt1        : one-cycle grant pulses (controller -> requester)
//   busy, done       : controller status, done is a one-cycle pulse
//   done_id          : requester whose result is on out
//   out              : zero-extended unsigned dot product
// Modports: master = requester side, slave = controller side.
interface dot_seq_ctrl_if
  import dot_seq_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);

  logic               req0;
  logic               req1;
  logic [N*W-1:0]     a0;
  logic [N*W-1:0]     b0;
  logic [N*W-1:0]     a1;
  logic [N*W-1:0]     b1;
  logic               gnt0;
  logic               gnt1;
  logic               busy;
  logic               done;
  logic               done_id;
  logic [2*N*W-1:0]   out;

  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, out
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output gnt0, gnt1, busy, done, done_id, out
  );

endinterface

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath: acc <= acc + a*b when en is high.
//   clk, rst : clock and synchronous active-low reset
//   a, b     : unsigned W-bit elements
//   clr      : clears the accumulator (takes priority over en)
//   en       : adds a*b this cycle
//   acc      : AW-bit accumulator
module mac_unit
  import dot_seq_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = 2 * DEF_W + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] acc
);

  logic [2*W-1:0] prod_next;
  logic [AW-1:0]  acc_reg;
  logic [AW-1:0]  acc_next;

  always_comb begin
    prod_next = (2*W)'(a) * (2*W)'(b);
    acc_next  = acc_reg + AW'(prod_next);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/dot_seq_ctrl.sv
// Two-requester round-robin dot-product sequencer.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-low reset
//   bus : dot_seq_ctrl_if slave modport (requests, operands, grants, result)
// Flow: IDLE -> LOAD (grant + operand capture) -> MAC (N cycles) -> DONE.
// Interface parameters must match N and W of this module.
module dot_seq_ctrl
  import dot_seq_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  dot_seq_ctrl_if.slave  bus
);

  localparam int AW = acc_width(N, W);
  localparam int CW = cnt_width(N);
  localparam int OW = 2 * N * W;

  state_t          state_reg;
  state_t          state_next;

  logic            sel_reg;          // winner chosen on the IDLE->LOAD edge
  logic            win_next;
  logic            last_served_reg;
  logic            done_id_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N*W-1:0]  a_reg;
  logic [N*W-1:0]  b_reg;
  logic [OW-1:0]   out_reg;

  logic [W-1:0]    a_elem [N];
  logic [W-1:0]    b_elem [N];
  logic [W-1:0]    a_cur;
  logic [W-1:0]    b_cur;
  logic            mac_clr;
  logic            mac_en;
  logic [AW-1:0]   acc;

  // Element i lives in the slice counted from the MSB end.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign a_elem[gi] = a_reg[(N-1-gi)*W +: W];
    assign b_elem[gi] = b_reg[(N-1-gi)*W +: W];
  end

  // Sole requester wins; on a tie the one not served last time wins.
  always_comb begin
    win_next = bus.req1;
    if (bus.req0 && bus.req1) begin
      win_next = ~last_served_reg;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req0 || bus.req1) state_next = LOAD;
      LOAD:    state_next = MAC;
      MAC:     if (cnt_reg == CW'(N - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.gnt0 = 1'b0;
    bus.gnt1 = 1'b0;
    bus.done = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    // The result is shown straight from the accumulator during DONE and is
    // held in out_reg afterwards, so out only moves on a DONE.
    bus.out  = out_reg;
    case (state_reg)
      LOAD: begin
        bus.gnt0 = ~sel_reg;
        bus.gnt1 = sel_reg;
        mac_clr  = 1'b1;
      end
      MAC: begin
        mac_en = 1'b1;
      end
      DONE: begin
        bus.done = 1'b1;
        bus.out  = OW'(acc);
      end
      default: ;
    endcase
    bus.busy    = (state_reg != IDLE);
    bus.done_id = done_id_reg;
  end

  // Control/datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_reg         <= 1'b0;
      last_served_reg <= 1'b1;
      done_id_reg     <= 1'b0;
      cnt_reg         <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      out_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            sel_reg <= win_next;
          end
        end
        LOAD: begin
          a_reg           <= sel_reg ? bus.a1 : bus.a0;
          b_reg           <= sel_reg ? bus.b1 : bus.b0;
          last_served_reg <= sel_reg;
          done_id_reg     <= sel_reg;
          cnt_reg         <= '0;
        end
        MAC: begin
          cnt_reg <= cnt_reg + CW'(1);
        end
        DONE: begin
          out_reg <= OW'(acc);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    a_cur = a_elem[cnt_reg];
    b_cur = b_elem[cnt_reg];
  end

  mac_unit #(
    .W  (W),
    .AW (AW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .a   (a_cur),
    .b   (b_cur),
    .clr (mac_clr),
    .en  (mac_en),
    .acc (acc)
  );

endmodule

// File: tb/tb_dot_seq_ctrl.sv
module tb_dot_seq_ctrl;

  localparam int N = 3;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dot_seq_ctrl_if #(.N(N), .W(W)) bus ();

  dot_seq_ctrl #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ncmp = 0;
  int nerr = 0;

  // mode 0: plain, 1: operands scrambled after capture, 2: req1 poked while busy
  typedef struct {
    logic        r0;
    logic        r1;
    logic [23:0] a0;
    logic [23:0] b0;
    logic [23:0] a1;
    logic [23:0] b1;
    int          mode;
    logic [47:0] exp_out;
    logic        exp_id;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [23:0] pk(input int e0, input int e1, input int e2);
    return {8'(e0), 8'(e1), 8'(e2)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [47:0] prev_out;
    bit          held;
    int          t;
    int          g;
    prev_out  = bus.out;
    held      = 1'b1;
    bus.req0  = v.r0;
    bus.req1  = v.r1;
    bus.a0    = v.a0;
    bus.b0    = v.b0;
    bus.a1    = v.a1;
    bus.b1    = v.b1;
    tick();
    t = 1;
    chk("grant", {bus.gnt1, bus.gnt0}, {v.exp_id, ~v.exp_id});
    if (bus.out !== prev_out) held = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    while (t < 20) begin
      tick();
      t++;
      if (v.mode == 1 && t == 2) begin
        bus.a0 = '1; bus.b0 = '1; bus.a1 = '1; bus.b1 = '1;
      end
      if (v.mode == 2) bus.req1 = (t >= 2 && t <= 3);
      if (bus.done) break;
      if (bus.out !== prev_out) held = 1'b0;
    end
    chk("latency", 64'(t), 64'd5);
    chk("out", bus.out, v.exp_out);
    chk("done_id", bus.done_id, v.exp_id);
    $display("txn %0d: req=%b%b out=%0d id=%0d latency=%0d", idx, v.r1, v.r0, bus.out, bus.done_id, t);
    tick();
    chk("out_hold", bus.out, v.exp_out);
    chk("idle_after_done", {bus.busy, bus.done}, 2'b00);
    chk("out_stable_during_op", held, 1'b1);
    if (v.mode == 2) begin
      g = 0;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (bus.gnt0 || bus.gnt1 || bus.busy) g = 1;
      end
      chk("busy_req_ignored", 64'(g), 64'd0);
    end
  endtask

  logic [47:0] got_out [3];
  logic        got_id  [3];
  int          got_t   [3];

  initial begin
    int t;
    int nd;
    int seen;

    vecs[0] = '{1'b1, 1'b0, pk(1,2,3),       pk(1,2,3),       pk(7,7,7),   pk(9,9,9),  0, 48'd14,     1'b0};
    vecs[1] = '{1'b0, 1'b1, pk(4,4,4),       pk(4,4,4),       pk(10,5,2),  pk(10,5,2), 0, 48'd129,    1'b1};
    vecs[2] = '{1'b1, 1'b0, pk(255,255,255), pk(255,255,255), pk(1,1,1),   pk(1,1,1),  0, 48'd195075, 1'b0};
    vecs[3] = '{1'b0, 1'b1, pk(0,0,0),       pk(0,0,0),       pk(3,4,5),   pk(6,7,8),  0, 48'd86,     1'b1};
    vecs[4] = '{1'b1, 1'b0, pk(1,0,255),     pk(255,7,255),   pk(2,2,2),   pk(2,2,2),  0, 48'd65280,  1'b0};
    vecs[5] = '{1'b1, 1'b0, pk(0,0,0),       pk(0,0,0),       pk(5,5,5),   pk(5,5,5),  0, 48'd0,      1'b0};
    vecs[6] = '{1'b1, 1'b0, pk(2,2,2),       pk(2,2,2),       pk(3,3,3),   pk(3,3,3),  1, 48'd12,     1'b0};
    vecs[7] = '{1'b1, 1'b0, pk(1,2,3),       pk(1,2,3),       pk(10,5,2),  pk(10,5,2), 2, 48'd14,     1'b0};
    vecs[8] = '{1'b0, 1'b1, pk(9,9,9),       pk(9,9,9),       pk(255,255,255), pk(1,1,1), 0, 48'd765, 1'b1};

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_out", bus.out, 48'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("rst_done_id", bus.done_id, 1'b0);

    // Both requesting from reset release: 0, 1, 0 round robin
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.a0 = pk(1,2,3);  bus.b0 = pk(1,2,3);
    bus.a1 = pk(10,5,2); bus.b1 = pk(10,5,2);
    tick();
    rst = 1'b1;
    t = 0; nd = 0;
    for (int k = 0; k < 3; k++) begin
      got_out[k] = '0; got_id[k] = 1'b0; got_t[k] = 0;
    end
    while (t < 30 && nd < 3) begin
      tick();
      t++;
      if (bus.done) begin
        got_out[nd] = bus.out;
        got_id[nd]  = bus.done_id;
        got_t[nd]   = t;
        $display("txn rr%0d: out=%0d id=%0d at cycle %0d", nd, bus.out, bus.done_id, t);
        nd++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("rr_count", 64'(nd), 64'd3);
    chk("rr_out0", got_out[0], 48'd14);
    chk("rr_id0", got_id[0], 1'b0);
    chk("rr_t0", 64'(got_t[0]), 64'd5);
    chk("rr_out1", got_out[1], 48'd129);
    chk("rr_id1", got_id[1], 1'b1);
    chk("rr_t1", 64'(got_t[1]), 64'd11);
    chk("rr_out2", got_out[2], 48'd14);
    chk("rr_id2", got_id[2], 1'b0);
    tick();
    chk("rr_idle", bus.busy, 1'b0);

    // Single-requester table
    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset during the second MAC cycle
    bus.req0 = 1'b1; bus.req1 = 1'b0;
    bus.a0 = pk(1,2,3); bus.b0 = pk(1,2,3);
    tick();
    bus.req0 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("abort_out", bus.out, 48'd0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done || bus.busy) seen = 1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    $display("txn abort: out=%0d busy=%0d", bus.out, bus.busy);
    run_vec(9, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/dot_seq_ctrl.md
DOT_SEQ_CTRL -- requirements
Module: dot_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, number of vector elements.
REQ-002 SHALL have parameter W, default 8, unsigned element width in bits.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports req0, req1  input  1 each  request from requester 0 and requester 1.
REQ-006 SHALL have ports a0, b0, a1, b1  input  N*W each  operand vectors; element 0 occupies the MSB slice, [(N-1-i)*W +: W] holds element i.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  one-cycle grant pulse; operands of the granted requester are captured in that cycle.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port done_id  output  1  index of the requester whose result is on out, valid with done.
REQ-011 SHALL have port out  output  2*N*W  unsigned dot product, zero-extended.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, MAC and DONE.
REQ-013 IDLE SHALL go to LOAD on the edge where req0 or req1 is high; otherwise it SHALL stay in IDLE.
REQ-014 LOAD SHALL assert the grant for exactly one cycle, capture the winner's a/b into internal registers, clear the accumulator, clear the element counter and record done_id; it SHALL then go to MAC.
REQ-015 MAC SHALL last exactly N cycles; on cycle i (i = 0..N-1) it SHALL add a[i]*b[i] to the accumulator; after i = N-1 it SHALL go to DONE.
REQ-016 DONE SHALL assert done for one cycle and load out with the accumulator, then return to IDLE.
REQ-017 Latency: done SHALL be high N+2 cycles after the edge that samples the request (N=3: 5 cycles); a new request SHALL be accepted no earlier than the cycle after DONE.
REQ-018 Arbitration SHALL be round-robin via a last_served bit: a sole requester wins; when both request, the requester not equal to last_served wins; last_served SHALL update in LOAD.
REQ-019 A requester SHALL hold req and its operands stable until its grant; a req deasserted before its grant SHALL cause no operation.
REQ-020 A request still high after its own DONE SHALL be treated as a new request.
REQ-021 Operand changes after the grant SHALL NOT affect the result in progress.
REQ-022 out SHALL hold its value from DONE until the next DONE or reset; out SHALL NOT change in IDLE, LOAD or MAC.
REQ-023 The accumulator SHALL be at least 2*W+clog2(N) bits; arithmetic SHALL be unsigned with no overflow for any input (max N*(2^W-1)^2).
REQ-024 While busy, req0 and req1 SHALL be ignored; they SHALL NOT be queued internally.

Reset
REQ-025 With rst low at a rising edge: state = IDLE, out = 0, done = 0, done_id = 0, gnt0 = gnt1 = 0, busy = 0, accumulator and counter = 0, last_served = 1 (req0 wins the first tie).
REQ-026 Reset asserted in any state, including mid-MAC, SHALL abort the operation with no done pulse; the next request after reset release SHALL start from LOAD normally.

Structure
REQ-027 A shared package dot_seq_pkg SHALL hold the FSM state encoding (2-bit: IDLE=0, LOAD=1, MAC=2, DONE=3) and the default N/W constants.
REQ-028 The multiply-accumulate datapath SHALL be a sub-module mac_unit (inputs: element a, element b, clear, enable; output: accumulator); arbitration, counter and FSM SHALL stay in dot_seq_ctrl.

Verification
REQ-029 req0 only, a0=b0={1,2,3} -> gnt0 in cycle 1, done 5 cycles after request sampling, out=14, done_id=0.
REQ-030 req1 only, a1=b1={10,5,2} -> gnt1, out=129, done_id=1.
REQ-031 req0 and req1 both held from reset release, a0=b0={1,2,3}, a1=b1={10,5,2} -> first done out=14/id 0, second done out=129/id 1, then third done out=14/id 0.
REQ-032 All elements 255, N=3 -> out=195075, no overflow.
REQ-033 rst pulsed low during the second MAC cycle -> no done, out=0 and busy=0 after the edge; the following request completes with the correct value.
REQ-034 Operands changed on the cycle after the grant -> out equals the dot product of the operands captured at the grant.
